// File: rtl/beat_seq_pkg.sv
// beat_seq_pkg: shared constants for the beat step sequencer.
//   - Avalon word addresses of the register map
//   - CONTROL / STATUS bit positions
//   - default pattern depth and data width
//   - step FSM state type and the STEP_LEN normalisation helper
package beat_seq_pkg;

  localparam int STEPS  = 16;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  localparam logic [4:0] ADDR_STATUS       = 5'd0;
  localparam logic [4:0] ADDR_CONTROL      = 5'd1;
  localparam logic [4:0] ADDR_TPS          = 5'd2;
  localparam logic [4:0] ADDR_STEP_LEN     = 5'd3;
  localparam logic [4:0] ADDR_STEP_POS     = 5'd4;
  localparam logic [4:0] ADDR_PATTERN_BASE = 5'd16;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_START  = 2;
  localparam int CTRL_STOP   = 3;

  localparam int STAT_BAR_DONE = 0;
  localparam int STAT_RUNNING  = 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RUNNING = 1'b1
  } seq_state_e;

  // Bar length actually used: 0 or anything above 16 means a full 16-step bar.
  function automatic logic [4:0] eff_step_len(input logic [4:0] len);
    if ((len == 5'd0) || (len > 5'd16)) begin
      return 5'd16;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/seq_pattern_ram.sv
// seq_pattern_ram: N_STEPS x WIDTH note-mask register file.
//   clk, reset_n            : clock, async active-low reset (clears all entries)
//   wr_en, wr_idx, wr_data  : synchronous write port
//   rd_a_idx / rd_a_data    : asynchronous read port for the CPU read mux
//   rd_b_idx / rd_b_data    : asynchronous read port for the next-step note mask
module seq_pattern_ram #(
  parameter int N_STEPS = 16,
  parameter int WIDTH   = 16,
  parameter int IDX_W   = $clog2(N_STEPS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_a_idx,
  output logic [WIDTH-1:0] rd_a_data,
  input  logic [IDX_W-1:0] rd_b_idx,
  output logic [WIDTH-1:0] rd_b_data
);

  logic [WIDTH-1:0] mem_r [N_STEPS];

  // Pattern storage; contents are lost on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_STEPS; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  assign rd_a_data = mem_r[rd_a_idx];
  assign rd_b_data = mem_r[rd_b_idx];

endmodule

// File: rtl/beat_step_sequencer.sv
// beat_step_sequencer: Avalon-MM slave that advances a programmed note pattern
// on interval-timer ticks and interrupts once per completed bar.
//   clk, reset_n                          : clock, async active-low reset
//   address, chipselect, write_n,
//   writedata, readdata                   : Avalon-MM slave, 1-cycle read latency
//   tick                                  : one-cycle timebase pulse
//   note_mask                             : note enables for the current step
//   step_pulse                            : one-cycle pulse per step advance
//   irq                                   : bar_done && irq_enable
module beat_step_sequencer
  import beat_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        tick,
  output logic [15:0] note_mask,
  output logic        step_pulse,
  output logic        irq
);

  seq_state_e  state_r, state_next_s;
  logic [15:0] tick_cnt_r, tick_cnt_next_s;
  logic [3:0]  step_r, step_next_s;
  logic        bar_done_r, bar_done_next_s;
  logic        irq_en_r, irq_en_next_s;
  logic        loop_r, loop_next_s;
  logic [15:0] tps_r;
  logic [4:0]  len_r;

  logic        wr_s, wr_status_s, wr_control_s, wr_tps_s, wr_len_s, wr_pos_s, wr_pat_s;
  logic        start_s, stop_s, running_s, advance_s, wrap_s;
  logic [15:0] eff_tps_s, rd_mux_s, pat_cpu_s, pat_next_s;
  logic [4:0]  eff_len_s;

  assign wr_s         = chipselect & ~write_n;
  assign wr_status_s  = wr_s & (address == ADDR_STATUS);
  assign wr_control_s = wr_s & (address == ADDR_CONTROL);
  assign wr_tps_s     = wr_s & (address == ADDR_TPS);
  assign wr_len_s     = wr_s & (address == ADDR_STEP_LEN);
  assign wr_pos_s     = wr_s & (address == ADDR_STEP_POS);
  assign wr_pat_s     = wr_s & address[4];
  assign start_s      = wr_control_s & writedata[CTRL_START];
  assign stop_s       = wr_control_s & writedata[CTRL_STOP];

  assign running_s = (state_r == ST_RUNNING);
  assign eff_tps_s = (tps_r == 16'd0) ? 16'd1 : tps_r;
  assign eff_len_s = eff_step_len(len_r);
  assign advance_s = running_s & tick & (tick_cnt_r == (eff_tps_s - 16'd1));
  // >= rather than == so a STEP_LEN shrunk below the current step wraps next advance.
  assign wrap_s    = ({1'b0, step_r} >= (eff_len_s - 5'd1));

  assign irq_en_next_s = wr_control_s ? writedata[CTRL_IRQ_EN] : irq_en_r;
  assign loop_next_s   = wr_control_s ? writedata[CTRL_LOOP]   : loop_r;

  seq_pattern_ram #(.N_STEPS(STEPS), .WIDTH(DATA_W)) u_ram (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_pat_s),
    .wr_idx    (address[3:0]),
    .wr_data   (writedata),
    .rd_a_idx  (address[3:0]),
    .rd_a_data (pat_cpu_s),
    .rd_b_idx  (step_next_s),
    .rd_b_data (pat_next_s)
  );

  // Step FSM next state, tick counter and bar_done; CPU writes override the sequencer.
  always_comb begin
    state_next_s    = state_r;
    tick_cnt_next_s = tick_cnt_r;
    step_next_s     = step_r;
    bar_done_next_s = bar_done_r;
    case (state_r)
      ST_IDLE: begin
        state_next_s = ST_IDLE;
      end
      ST_RUNNING: begin
        if (tick) begin
          tick_cnt_next_s = advance_s ? 16'd0 : (tick_cnt_r + 16'd1);
        end else begin
          tick_cnt_next_s = tick_cnt_r;
        end
        if (advance_s && wrap_s) begin
          step_next_s     = 4'd0;
          bar_done_next_s = 1'b1;
          state_next_s    = loop_r ? ST_RUNNING : ST_IDLE;
        end else if (advance_s) begin
          step_next_s = step_r + 4'd1;
        end else begin
          step_next_s = step_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    if (wr_tps_s || wr_pos_s || start_s) begin
      tick_cnt_next_s = 16'd0;
    end else begin
      tick_cnt_next_s = tick_cnt_next_s;
    end
    if (wr_pos_s) begin
      step_next_s = writedata[3:0];
    end else begin
      step_next_s = step_next_s;
    end
    if (wr_status_s) begin
      bar_done_next_s = 1'b0;
    end else begin
      bar_done_next_s = bar_done_next_s;
    end
    if (start_s) begin
      state_next_s = ST_RUNNING;
    end else if (stop_s) begin
      state_next_s = ST_IDLE;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // CPU read mux; pattern entries occupy the upper half of the address space.
  always_comb begin
    rd_mux_s = 16'd0;
    case (address)
      ADDR_STATUS:   rd_mux_s = {14'd0, running_s, bar_done_r};
      ADDR_CONTROL:  rd_mux_s = {14'd0, loop_r, irq_en_r};
      ADDR_TPS:      rd_mux_s = tps_r;
      ADDR_STEP_LEN: rd_mux_s = {11'd0, len_r};
      ADDR_STEP_POS: rd_mux_s = {12'd0, step_r};
      default:       rd_mux_s = address[4] ? pat_cpu_s : 16'd0;
    endcase
  end

  // State, configuration and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= 16'd0;
      step_r     <= 4'd0;
      bar_done_r <= 1'b0;
      irq_en_r   <= 1'b0;
      loop_r     <= 1'b0;
      tps_r      <= 16'd1;
      len_r      <= 5'd16;
      note_mask  <= 16'd0;
      step_pulse <= 1'b0;
      irq        <= 1'b0;
      readdata   <= 16'd0;
    end else begin
      state_r    <= state_next_s;
      tick_cnt_r <= tick_cnt_next_s;
      step_r     <= step_next_s;
      bar_done_r <= bar_done_next_s;
      irq_en_r   <= irq_en_next_s;
      loop_r     <= loop_next_s;
      tps_r      <= wr_tps_s ? writedata : tps_r;
      len_r      <= wr_len_s ? writedata[4:0] : len_r;
      note_mask  <= (state_next_s == ST_RUNNING) ? pat_next_s : 16'd0;
      step_pulse <= advance_s;
      irq        <= bar_done_next_s & irq_en_next_s;
      readdata   <= chipselect ? rd_mux_s : 16'd0;
    end
  end

endmodule

// File: tb/tb_beat_step_sequencer.sv
// tb_beat_step_sequencer: directed stimulus with a scoreboard. Stimulus pushes
// expected observations tagged with the cycle they are due; a negedge monitor
// pops and compares them against the DUT outputs.
module tb_beat_step_sequencer;

  localparam int K_RD    = 0;
  localparam int K_NOTE  = 1;
  localparam int K_IRQ   = 2;
  localparam int K_PULSE = 3;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
    string       name;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        tick;
  logic [15:0] note_mask;
  logic        step_pulse;
  logic        irq;

  sb_item_t sb[$];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  bit done = 1'b0;

  beat_step_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .tick       (tick),
    .note_mask  (note_mask),
    .step_pulse (step_pulse),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every scoreboard entry that has come due.
  always @(negedge clk) begin
    logic [15:0] got;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          K_RD:    got = readdata;
          K_NOTE:  got = note_mask;
          K_IRQ:   got = {15'd0, irq};
          K_PULSE: got = {15'd0, step_pulse};
          default: got = 16'hxxxx;
        endcase
        n_vec++;
        if ((sb[i].due != cyc) || (got !== sb[i].exp)) begin
          n_err++;
          $display("FAIL %s @cyc %0d (due %0d): got %h expected %h",
                   sb[i].name, cyc, sb[i].due, got, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  // Watchdog: the test must complete within a bounded time.
  initial begin
    #200000;
    if (!done) begin
      n_err++;
      $display("FAIL watchdog: test did not finish before the wait expired");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input logic [15:0] got, input logic [15:0] e, input string nm);
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, e);
    end
  endtask

  task automatic push(input int kind, input int due, input logic [15:0] e, input string nm);
    sb_item_t it;
    it.due  = due;
    it.kind = kind;
    it.exp  = e;
    it.name = nm;
    sb.push_back(it);
  endtask

  task automatic expect_now(input int kind, input logic [15:0] e, input string nm);
    push(kind, cyc, e, nm);
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    cycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [15:0] e, input string nm);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    push(K_RD, cyc + 1, e, nm);
    cycle();
    chipselect = 1'b0;
  endtask

  logic [15:0] pat_a [4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
  logic [15:0] pat_b [4] = '{16'h0001, 16'h0002, 16'hBEEF, 16'h0008};

  initial begin
    reset_n    = 1'b0;
    address    = 5'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'd0;
    tick       = 1'b0;
    repeat (3) cycle();
    reset_n = 1'b1;
    cycle();

    // Reset state
    check_eq(note_mask, 16'h0000, "reset_note");
    check_eq({15'd0, irq}, 16'h0000, "reset_irq");
    check_eq({15'd0, step_pulse}, 16'h0000, "reset_pulse");
    rd(5'd0, 16'h0000, "reset_status");
    rd(5'd1, 16'h0000, "reset_control");
    rd(5'd2, 16'h0001, "reset_tps");
    rd(5'd3, 16'h0010, "reset_step_len");
    rd(5'd4, 16'h0000, "reset_step_pos");
    rd(5'd16, 16'h0000, "reset_pat0");
    rd(5'd31, 16'h0000, "reset_pat15");
    rd(5'd7, 16'h0000, "unmapped_read");

    // Looping 4-step bar, 3 ticks per step
    wr(5'd16, 16'h0001);
    wr(5'd17, 16'h0002);
    wr(5'd18, 16'h0004);
    wr(5'd19, 16'h0008);
    rd(5'd18, 16'h0004, "pat2_readback");
    wr(5'd3, 16'd4);
    wr(5'd2, 16'd3);
    wr(5'd1, 16'h0007);
    expect_now(K_NOTE, 16'h0001, "start_note");
    tick = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      expect_now(K_NOTE, pat_a[(i / 3) % 4], "loop_note");
      expect_now(K_PULSE, {15'd0, (i % 3) == 0}, "loop_pulse");
      expect_now(K_IRQ, {15'd0, i == 12}, "loop_irq");
    end
    tick = 1'b0;
    rd(5'd4, 16'h0000, "loop_step_after_bar");
    rd(5'd1, 16'h0003, "control_readback");
    rd(5'd0, 16'h0003, "status_bar_running");

    // STATUS clear on the same edge as the next wrap: clear wins
    tick = 1'b1;
    repeat (11) cycle();
    expect_now(K_IRQ, 16'h0001, "irq_held_before_clear");
    wr(5'd0, 16'h0000);
    tick = 1'b0;
    expect_now(K_IRQ, 16'h0000, "clear_vs_wrap_irq");
    expect_now(K_PULSE, 16'h0001, "clear_vs_wrap_pulse");
    rd(5'd0, 16'h0002, "clear_vs_wrap_status");

    // Pattern write to the current step
    tick = 1'b1;
    repeat (6) cycle();
    tick = 1'b0;
    expect_now(K_NOTE, 16'h0004, "at_step2_note");
    wr(5'd18, 16'hBEEF);
    cycle();
    expect_now(K_NOTE, 16'hBEEF, "live_pattern_note");

    // Stop, then a non-looping bar
    wr(5'd1, 16'h000B);
    expect_now(K_NOTE, 16'h0000, "stop_note");
    wr(5'd4, 16'h0000);
    wr(5'd1, 16'h0005);
    expect_now(K_NOTE, 16'h0001, "oneshot_start_note");
    tick = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      expect_now(K_NOTE, (i == 12) ? 16'h0000 : pat_b[i / 3], "oneshot_note");
      expect_now(K_PULSE, {15'd0, (i % 3) == 0}, "oneshot_pulse");
    end
    expect_now(K_IRQ, 16'h0001, "oneshot_irq");
    for (int i = 0; i < 10; i++) begin
      cycle();
      expect_now(K_PULSE, 16'h0000, "idle_tick_pulse");
      expect_now(K_NOTE, 16'h0000, "idle_tick_note");
    end
    tick = 1'b0;
    rd(5'd0, 16'h0001, "oneshot_status");
    rd(5'd4, 16'h0000, "oneshot_step_pos");
    wr(5'd0, 16'h1234);
    expect_now(K_IRQ, 16'h0000, "status_write_clears_irq");

    // start+stop in one write: start wins
    wr(5'd1, 16'h000C);
    expect_now(K_NOTE, 16'h0001, "start_stop_note");
    rd(5'd0, 16'h0002, "start_stop_status");
    rd(5'd1, 16'h0000, "strobes_read_zero");

    // TICKS_PER_STEP 0 acts as 1; STEP_POS load; STEP_LEN 0 acts as 16
    wr(5'd2, 16'd0);
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    expect_now(K_NOTE, 16'h0002, "tps0_note");
    expect_now(K_PULSE, 16'h0001, "tps0_pulse");
    rd(5'd2, 16'h0000, "tps0_raw_read");
    wr(5'd4, 16'd3);
    expect_now(K_NOTE, 16'h0008, "step_pos_load_note");
    wr(5'd3, 16'd0);
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    expect_now(K_NOTE, 16'h0000, "len0_step4_note");
    expect_now(K_PULSE, 16'h0001, "len0_step4_pulse");
    rd(5'd4, 16'h0004, "len0_step_pos");

    // Run to a wrap of a 16-step bar, then reset mid-bar
    wr(5'd1, 16'h0007);
    tick = 1'b1;
    repeat (12) cycle();
    expect_now(K_IRQ, 16'h0001, "len16_wrap_irq");
    expect_now(K_NOTE, 16'h0001, "len16_wrap_note");
    cycle();
    tick = 1'b0;
    expect_now(K_NOTE, 16'h0002, "midbar_note");
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = 5'd17;
    push(K_RD, cyc + 1, 16'h0002, "midbar_read");
    cycle();
    cycle();
    reset_n = 1'b0;
    expect_now(K_NOTE, 16'h0000, "async_reset_note");
    expect_now(K_IRQ, 16'h0000, "async_reset_irq");
    expect_now(K_RD, 16'h0000, "async_reset_readdata");
    chipselect = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
    rd(5'd2, 16'h0001, "post_reset_tps");
    rd(5'd17, 16'h0000, "post_reset_pattern_lost");
    rd(5'd0, 16'h0000, "post_reset_status");

    repeat (3) cycle();
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/beat_step_sequencer.md
# beat_step_sequencer

Avalon-MM slave (16-bit data) that sits directly downstream of the SoC interval timer. It consumes the timer's one-cycle periodic tick and advances through a CPU-programmed pattern of up to 16 steps. At each step it drives a 16-bit note-enable mask to the tone generators. It raises an interrupt once per completed bar, so the Nios ISR only needs to refill or modify patterns instead of servicing every timer tick.

## Interface
- STEPS, 16, number of pattern entries (address space sized for 16)
- DATA_W, 16, Avalon data width and note-mask width
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  5  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe (writes act when chipselect && ~write_n)
- writedata  in  16  write data
- readdata  out  16  registered read data
- tick  in  1  one-cycle timebase pulse from interval timer timeout
- note_mask  out  16  registered note enables for current step
- step_pulse  out  1  one-cycle pulse on every step advance
- irq  out  1  bar_done && irq_enable

## Operation
- Address map:
  - 0 STATUS: bit0 bar_done, bit1 running (read); any write clears bar_done.
  - 1 CONTROL: bit0 irq_enable, bit1 loop (stored); bit2 start, bit3 stop (write-only strobes, read back as 0).
  - 2 TICKS_PER_STEP: 16-bit; value 0 treated as 1.
  - 3 STEP_LEN: bits[4:0]; values 0 or >16 treated as 16.
  - 4 STEP_POS: read current step index [3:0]; write loads index = writedata[3:0] and clears tick_cnt.
  - 16..31 PATTERN[0..15]: note masks, R/W.
  - Other addresses read 0; writes ignored.
- Counting, only while running and tick=1:
  - If tick_cnt == eff_tps-1: tick_cnt<=0, advance step. Otherwise tick_cnt++.
- Step advance:
  - step_pulse=1.
  - If step >= eff_len-1: step<=0, bar_done<=1, and running<=0 when loop=0.
  - Otherwise step++.
- Start/stop:
  - start strobe sets running and clears tick_cnt; step is not altered.
  - stop strobe clears running.
  - start && stop in the same write: start wins.
- note_mask <= running_next ? PATTERN[step_next] : 0, evaluated every cycle. A pattern write to the current step is therefore visible on the next cycle.
- Writing TICKS_PER_STEP clears tick_cnt.
- Writing STEP_LEN below current step+1 takes effect as a wrap to 0 at the next advance.

## Timing
- Reset values:
  - readdata=0, note_mask=0, step_pulse=0, irq=0.
  - running=0, bar_done=0, step=0, tick_cnt=0.
  - CONTROL=0, TICKS_PER_STEP=1, STEP_LEN=16, all PATTERN=0.
- Read latency: 1 cycle. readdata reflects address sampled at the previous edge; no waitrequest.
- Advance latency: step, step_pulse and bar_done update on the edge sampling the terminal tick. note_mask shows the new step's pattern on that same edge; irq is asserted that edge when irq_enable=1.
- Simultaneous STATUS write and bar event: clear wins, so bar_done=0.
- Simultaneous STEP_POS write and advance: the write wins.
- Simultaneous stop and advance: running=0 and step advances.
- A tick while not running is ignored; tick_cnt holds.
- Asynchronous reset mid-bar returns everything to reset values immediately; the pattern contents are lost.

## Structure
- Package beat_seq_pkg holds:
  - address constants (ADDR_STATUS..ADDR_PATTERN_BASE)
  - CONTROL bit indices
  - STEPS and DATA_W defaults
- Sub-module seq_pattern_ram: STEPS x DATA_W register file with a synchronous write port and two asynchronous read ports, one for the CPU read mux and one for step_next.
- Top level holds the register file decode, tick counter, step FSM (IDLE/RUNNING, tracked by the running bit), irq latch and read mux.

## Test plan
- Reset, then read all registers -> STATUS=0, TICKS_PER_STEP=1, STEP_LEN=16, PATTERN[n]=0, note_mask=0, irq=0.
- Set PATTERN[0..3]=0x0001,0x0002,0x0004,0x0008, STEP_LEN=4, TICKS_PER_STEP=3, CONTROL=0x0007, then 12 ticks:
  - note_mask steps 0x0001 -> 0x0002 -> 0x0004 -> 0x0008 every 3 ticks;
  - step_pulse fires 4 times;
  - after tick 12, irq=1 and step=0.
- Same setup with loop=0:
  - after 4 steps, running=0 and note_mask=0;
  - a further 10 ticks produce no step_pulse.
- With bar_done=1, write STATUS on the same edge as the next bar wrap -> bar_done=0 and irq=0.
- While running at step 2, write PATTERN[2]=0xBEEF -> note_mask=0xBEEF on the next cycle.
- Write CONTROL=0x000C (start+stop) while stopped -> running=1.
- Assert reset_n low mid-bar -> note_mask, irq and readdata drop to 0 at once.
